// File: rtl/kyrillos_mem_pkg.sv
// -----------------------------------------------------------------------------
// kyrillos_mem_pkg
// Shared types for the kyrillos_mem_v2 scratch RAM:
//   mem_state_t : controller state (IDLE / CLEAR sweep)
//   rsp_t       : response pipeline payload {vld, err, data}
//   be_merge()  : byte-enable merge of write data into an existing word
// The response payload width is fixed here. The top-level DATA_WIDTH
// parameter defaults to MEM_DATA_WIDTH and must stay equal to it.
// -----------------------------------------------------------------------------
package kyrillos_mem_pkg;

    localparam int MEM_DATA_WIDTH = 32;
    localparam int NBYTES         = MEM_DATA_WIDTH / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic                      vld;
        logic                      err;
        logic [MEM_DATA_WIDTH-1:0] data;
    } rsp_t;

    // Replace only the bytes whose enable bit is set.
    function automatic logic [MEM_DATA_WIDTH-1:0] be_merge(
        input logic [MEM_DATA_WIDTH-1:0] old_word,
        input logic [MEM_DATA_WIDTH-1:0] new_word,
        input logic [NBYTES-1:0]         be
    );
        logic [MEM_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/kyrillos_rsp_pipe.sv
// -----------------------------------------------------------------------------
// kyrillos_rsp_pipe
// Delay line of STAGES flops carrying rsp_t. STAGES=0 is a plain wire.
// All stages flush to zero on reset, so responses in flight are dropped.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous reset, active-high
//   rsp_i  in   response entering the delay line
//   rsp_o  out  response leaving the delay line
// -----------------------------------------------------------------------------
module kyrillos_rsp_pipe
    import kyrillos_mem_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic clk,
    input  logic rst,
    input  rsp_t rsp_i,
    output rsp_t rsp_o
);

    generate
        if (STAGES == 0) begin : g_bypass
            // clk/rst are not needed without storage.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign rsp_o = rsp_i;
        end else begin : g_stages
            rsp_t stage_q [STAGES];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < STAGES; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= rsp_i;
                    for (int i = 1; i < STAGES; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign rsp_o = stage_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/kyrillos_mem_v2.sv
// -----------------------------------------------------------------------------
// kyrillos_mem_v2
// Single-port synchronous scratch RAM with byte strobes, configurable read
// latency, address range checking and a hardware clear sweep that runs after
// every reset and on request.
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | sweep: zero mem[clr_ptr] each cycle, busy=1, requests dropped
// IDLE  | accept requests; CLR starts a new sweep from address 0
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-high
//   EN         in   request strobe
//   WR         in   1 = write, 0 = read
//   Address    in   word address
//   Data_in    in   write data
//   BE         in   byte enables for writes
//   CLR        in   request a clear sweep (IDLE only)
//   Data_out   out  read data, holds last read value between responses
//   valid_out  out  1-cycle read response pulse
//   err        out  1-cycle error response pulse
//   busy       out  clear sweep in progress
// -----------------------------------------------------------------------------
module kyrillos_mem_v2
    import kyrillos_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int DEPTH      = 2**ADDR_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    EN,
    input  logic                    WR,
    input  logic [ADDR_WIDTH-1:0]   Address,
    input  logic [DATA_WIDTH-1:0]   Data_in,
    input  logic [DATA_WIDTH/8-1:0] BE,
    input  logic                    CLR,
    output logic [DATA_WIDTH-1:0]   Data_out,
    output logic                    valid_out,
    output logic                    err,
    output logic                    busy
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    mem_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  accept;
    logic                  in_range;
    logic                  do_write;
    logic                  do_read;
    logic [DATA_WIDTH-1:0] rd_data;

    rsp_t                  rsp_s1_d, rsp_s1_q;
    rsp_t                  rsp_out;
    logic [DATA_WIDTH-1:0] data_hold_q;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (CLR) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            CLEAR: begin
                busy      = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                // CLR is ignored here so a running sweep is never restarted.
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request decode. CLR wins over a simultaneous EN.
    // ------------------------------------------------------------------
    assign accept   = EN && (state_q == IDLE) && !CLR;
    assign in_range = ({1'b0, Address} < DEPTH_L);
    assign do_write = accept &&  WR && in_range;
    assign do_read  = accept && !WR && in_range;

    // ------------------------------------------------------------------
    // Storage. The sweep and request writes are mutually exclusive because
    // requests are only accepted in IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (do_write) begin
            mem_q[Address] <= be_merge(mem_q[Address], Data_in, BE);
        end
    end

    assign rd_data = do_read ? mem_q[Address] : '0;

    // ------------------------------------------------------------------
    // Response stage 1 (array read), then RD_LATENCY-1 delay stages.
    // Any request that is dropped or out of range yields err; only reads
    // ever yield vld, and out-of-range reads carry zero data.
    // ------------------------------------------------------------------
    always_comb begin
        rsp_s1_d      = '0;
        rsp_s1_d.vld  = accept && !WR;
        rsp_s1_d.err  = EN && !(accept && in_range);
        rsp_s1_d.data = rd_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_s1_q <= '0;
        end else begin
            rsp_s1_q <= rsp_s1_d;
        end
    end

    kyrillos_rsp_pipe #(
        .STAGES (RD_LATENCY - 1)
    ) u_rsp_pipe (
        .clk   (clk),
        .rst   (rst),
        .rsp_i (rsp_s1_q),
        .rsp_o (rsp_out)
    );

    // Data_out shows the response in its valid cycle and otherwise the last
    // read value, so the hold register only needs to capture on vld.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_hold_q <= '0;
        end else if (rsp_out.vld) begin
            data_hold_q <= rsp_out.data;
        end
    end

    assign Data_out  = rsp_out.vld ? rsp_out.data : data_hold_q;
    assign valid_out = rsp_out.vld;
    assign err       = rsp_out.err;

endmodule

// File: tb/tb_kyrillos_mem_v2.sv
module tb_kyrillos_mem_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic        EN;
    logic        WR;
    logic [3:0]  Address;
    logic [31:0] Data_in;
    logic [3:0]  BE;
    logic        CLR;
    logic [31:0] Data_out;
    logic        valid_out;
    logic        err;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int n;
    logic        any_rsp;
    logic [31:0] exp_mem [12];

    always #5 clk = ~clk;

    kyrillos_mem_v2 #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (32),
        .DEPTH      (12),
        .RD_LATENCY (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .EN        (EN),
        .WR        (WR),
        .Address   (Address),
        .Data_in   (Data_in),
        .BE        (BE),
        .CLR       (CLR),
        .Data_out  (Data_out),
        .valid_out (valid_out),
        .err       (err),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reads 0..11 back to back and checks each response two cycles later.
    task automatic read_burst(input string tag);
        for (int i = 0; i <= 12; i++) begin
            if (i < 12) begin
                EN = 1'b1; WR = 1'b0; Address = 4'(i);
            end else begin
                EN = 1'b0;
            end
            tick();
            if (i >= 1) begin
                chk({tag, "_valid"}, {31'b0, valid_out}, 32'd1);
                chk({tag, "_err"},   {31'b0, err},       32'd0);
                chk({tag, "_data"},  Data_out,           exp_mem[i-1]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; EN = 1'b0; WR = 1'b0; Address = '0;
        Data_in = '0; BE = '0; CLR = 1'b0;
        for (int i = 0; i < 12; i++) exp_mem[i] = 32'h0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_busy",  {31'b0, busy},      32'd1);
        chk("rst_valid", {31'b0, valid_out}, 32'd0);
        chk("rst_err",   {31'b0, err},       32'd0);
        chk("rst_data",  Data_out,           32'h0);

        // 1. Sweep after reset lasts exactly 12 cycles, memory reads zero
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("sweep1_len", 32'(n), 32'd12);
        read_burst("clr0");

        // 2. Full write then byte-0 write, read back
        EN = 1'b1; WR = 1'b1; Address = 4'd3; Data_in = 32'hDEADBEEF; BE = 4'hF;
        tick();
        Data_in = 32'h000000AA; BE = 4'b0001;
        tick();
        chk("wr_no_valid", {31'b0, valid_out}, 32'd0);
        chk("wr_no_err",   {31'b0, err},       32'd0);
        EN = 1'b1; WR = 1'b0; Address = 4'd3; BE = 4'h0;
        tick();
        EN = 1'b0;
        chk("rd3_lat1_valid", {31'b0, valid_out}, 32'd0);
        tick();
        chk("rd3_valid", {31'b0, valid_out}, 32'd1);
        chk("rd3_err",   {31'b0, err},       32'd0);
        chk("rd3_data",  Data_out,           32'hDEADBEAA);
        tick();
        chk("rd3_pulse", {31'b0, valid_out}, 32'd0);
        chk("rd3_hold",  Data_out,           32'hDEADBEAA);

        // 3. Out-of-range read and write
        EN = 1'b1; WR = 1'b0; Address = 4'd13;
        tick();
        EN = 1'b0;
        tick();
        chk("oor_rd_valid", {31'b0, valid_out}, 32'd1);
        chk("oor_rd_err",   {31'b0, err},       32'd1);
        chk("oor_rd_data",  Data_out,           32'h0);
        EN = 1'b1; WR = 1'b1; Address = 4'd14; Data_in = 32'hFFFFFFFF; BE = 4'hF;
        tick();
        EN = 1'b0;
        tick();
        chk("oor_wr_err",   {31'b0, err},       32'd1);
        chk("oor_wr_valid", {31'b0, valid_out}, 32'd0);
        chk("oor_wr_hold",  Data_out,           32'h0);
        tick();
        chk("oor_wr_pulse", {31'b0, err},       32'd0);

        // BE=0 write is a silent no-op
        EN = 1'b1; WR = 1'b1; Address = 4'd3; Data_in = 32'h11111111; BE = 4'h0;
        tick();
        EN = 1'b0;
        tick();
        chk("be0_err", {31'b0, err}, 32'd0);

        // 4. Back-to-back reads, memory otherwise unchanged
        exp_mem[3] = 32'hDEADBEAA;
        read_burst("b2b");

        // 5. CLR with EN in IDLE, EN and CLR during the sweep
        EN = 1'b1; WR = 1'b0; Address = 4'd3; CLR = 1'b1;
        tick();
        Address = 4'd5;
        tick();
        chk("clr_en_err",   {31'b0, err},       32'd1);
        chk("clr_en_valid", {31'b0, valid_out}, 32'd0);
        chk("clr_busy",     {31'b0, busy},      32'd1);
        EN = 1'b0; CLR = 1'b0;
        tick();
        chk("busy_en_err",   {31'b0, err},       32'd1);
        chk("busy_en_valid", {31'b0, valid_out}, 32'd0);
        n = 2;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("sweep2_len", 32'(n), 32'd12);
        EN = 1'b1; WR = 1'b0; Address = 4'd3;
        tick();
        EN = 1'b0;
        tick();
        chk("post_clr_valid", {31'b0, valid_out}, 32'd1);
        chk("post_clr_data",  Data_out,           32'h0);

        // 6. Reset with two reads in flight
        EN = 1'b1; WR = 1'b1; Address = 4'd1; Data_in = 32'h12345678; BE = 4'hF;
        tick();
        WR = 1'b0; Address = 4'd1;
        tick();
        Address = 4'd2;
        tick();
        EN = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_fl_valid", {31'b0, valid_out}, 32'd0);
        chk("rst_fl_data",  Data_out,           32'h0);
        chk("rst_fl_busy",  {31'b0, busy},      32'd1);
        tick(); tick();
        rst = 1'b0;
        n = 0;
        any_rsp = 1'b0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
            any_rsp = any_rsp | valid_out | err;
        end
        chk("sweep3_len",  32'(n), 32'd12);
        chk("rst_no_rsp",  {31'b0, any_rsp}, 32'd0);
        EN = 1'b1; WR = 1'b0; Address = 4'd1;
        tick();
        EN = 1'b0;
        tick();
        chk("post_rst_valid", {31'b0, valid_out}, 32'd1);
        chk("post_rst_data",  Data_out,           32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
